// File: rtl/axil_gpio_responder.sv
// AXI4-Lite register block for the board LEDs and switches: LED drive, synchronised and
// debounced switch state, sticky change flags and a level interrupt.
module axil_gpio_responder #(
    parameter int          ADDR_WIDTH      = 5,
    parameter int          N_LED           = 4,
    parameter int          N_SW            = 4,
    parameter int          DEBOUNCE_CYCLES = 100000,
    parameter logic [31:0] BLOCK_ID        = 32'h454D0001
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [N_LED-1:0]      leds_tri_o,
    input  logic [N_SW-1:0]       sws_tri_i,
    output logic                  irq
);

    localparam int         CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [1:0] OKAY    = 2'b00;
    localparam logic [1:0] SLVERR  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic { W_IDLE, W_RESP } w_state_e;
    typedef enum logic { R_IDLE, R_DATA } r_state_e;

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              rvalid_q, rvalid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [N_LED-1:0]  led_q, led_d;
    logic [N_SW-1:0]   irq_en_q, irq_en_d;
    logic [N_SW-1:0]   sw_meta_q, sw_meta_d;
    logic [N_SW-1:0]   sw_sync_q, sw_sync_d;
    logic [N_SW-1:0]   sw_deb_q, sw_deb_d;
    logic [N_SW-1:0]   sw_edge_q, sw_edge_d;
    logic [CNT_W-1:0]  cnt_q [N_SW];
    logic [CNT_W-1:0]  cnt_d [N_SW];
    logic              irq_q, irq_d;

    logic              wr_fire, rd_fire;
    logic [2:0]        wr_sel, rd_sel;
    logic [31:0]       wmask;
    logic [N_SW-1:0]   edge_clr;
    logic [31:0]       rd_data;
    logic              rd_err;
    logic              unused_bits;

    // Handshake: AW and W are accepted together only, for the single cycle both valids are
    // seen in W_IDLE; AR is accepted in R_IDLE. B and R valids are registered and hold
    // their payload stable until the matching ready is sampled high.
    assign wr_fire       = (w_state_q == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
    assign rd_fire       = (r_state_q == R_IDLE) && s_axi_arvalid;
    assign s_axi_awready = wr_fire;
    assign s_axi_wready  = wr_fire;
    assign s_axi_arready = rd_fire;
    assign wr_sel        = s_axi_awaddr[4:2];
    assign rd_sel        = s_axi_araddr[4:2];
    assign wmask         = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}},
                            {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};
    assign unused_bits   = ^{s_axi_awaddr, s_axi_araddr, s_axi_wdata, wmask};

    always_comb begin
        w_state_d = w_state_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        led_d     = led_q;
        irq_en_d  = irq_en_q;
        edge_clr  = '0;
        case (w_state_q)
            W_IDLE: begin
                if (wr_fire) begin
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = (wr_sel > 3'd4) ? SLVERR : OKAY;
                    case (wr_sel)
                        3'd0: led_d = (led_q & ~wmask[N_LED-1:0]) |
                                      (s_axi_wdata[N_LED-1:0] & wmask[N_LED-1:0]);
                        3'd2: edge_clr = s_axi_wdata[N_SW-1:0] & wmask[N_SW-1:0];
                        3'd3: irq_en_d = (irq_en_q & ~wmask[N_SW-1:0]) |
                                         (s_axi_wdata[N_SW-1:0] & wmask[N_SW-1:0]);
                        default: ;
                    endcase
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    bresp_d   = OKAY;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (rd_sel)
            3'd0: rd_data[N_LED-1:0] = led_q;
            3'd1: rd_data[N_SW-1:0]  = sw_deb_q;
            3'd2: rd_data[N_SW-1:0]  = sw_edge_q;
            3'd3: rd_data[N_SW-1:0]  = irq_en_q;
            3'd4: rd_data            = BLOCK_ID;
            default: rd_err          = 1'b1;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (rd_fire) begin
                    r_state_d = R_DATA;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_data;
                    rresp_d   = rd_err ? SLVERR : OKAY;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // A bit must differ from its debounced value for DEBOUNCE_CYCLES consecutive cycles;
    // any cycle of agreement restarts the count.
    always_comb begin
        sw_meta_d = sws_tri_i;
        sw_sync_d = sw_meta_q;
        sw_deb_d  = sw_deb_q;
        for (int i = 0; i < N_SW; i++) begin
            cnt_d[i] = '0;
            if (sw_sync_q[i] != sw_deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    sw_deb_d[i] = sw_sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        // A new change outranks a same-cycle clear so no event is lost.
        sw_edge_d = (sw_edge_q & ~edge_clr) | (sw_deb_d ^ sw_deb_q);
        irq_d     = |(sw_edge_q & irq_en_q);
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
            led_q     <= '0;
            irq_en_q  <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            sw_deb_q  <= '0;
            sw_edge_q <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < N_SW; i++) cnt_q[i] <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            irq_en_q  <= irq_en_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            sw_deb_q  <= sw_deb_d;
            sw_edge_q <= sw_edge_d;
            irq_q     <= irq_d;
            for (int i = 0; i < N_SW; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rdata  = rdata_q;
    assign leds_tri_o   = led_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_axil_gpio_responder.sv
// Directed bench for axil_gpio_responder: register table plus timed switch and reset sequences.
module tb_axil_gpio_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [4:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  leds;
    logic [3:0]  sws = '0;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axil_gpio_responder #(
        .ADDR_WIDTH(5), .N_LED(4), .N_SW(4), .DEBOUNCE_CYCLES(8), .BLOCK_ID(32'h454D0001)
    ) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .leds_tri_o(leds), .sws_tri_i(sws), .irq(irq)
    );

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  exp_bresp;
        logic [4:0]  raddr;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
        logic [3:0]  exp_leds;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the B handshake.
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        #1;
        n = 0;
        while (!(awready && wready) && n < 50) begin tick(1); n++; end
        if (n >= 50) timeout("write_accept");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin tick(1); n++; end
        if (n >= 50) timeout("write_resp");
        resp = bresp;
        tick(1);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 50) begin tick(1); n++; end
        if (n >= 50) timeout("read_accept");
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin tick(1); n++; end
        if (n >= 50) timeout("read_data");
        data = rdata;
        resp = rresp;
        tick(1);
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;

        vecs[0]  = '{5'h00, 32'h0000000A, 4'hF, 2'b00, 5'h00, 32'h0000000A, 2'b00, 4'hA};
        vecs[1]  = '{5'h00, 32'hFFFFFFF5, 4'hE, 2'b00, 5'h00, 32'h0000000A, 2'b00, 4'hA};
        vecs[2]  = '{5'h00, 32'h00000005, 4'h0, 2'b00, 5'h00, 32'h0000000A, 2'b00, 4'hA};
        vecs[3]  = '{5'h00, 32'h00000005, 4'h1, 2'b00, 5'h00, 32'h00000005, 2'b00, 4'h5};
        vecs[4]  = '{5'h0C, 32'hFFFFFFFF, 4'hF, 2'b00, 5'h0C, 32'h0000000F, 2'b00, 4'h5};
        vecs[5]  = '{5'h0C, 32'h00000000, 4'hF, 2'b00, 5'h0C, 32'h00000000, 2'b00, 4'h5};
        vecs[6]  = '{5'h04, 32'h0000000F, 4'hF, 2'b00, 5'h04, 32'h00000000, 2'b00, 4'h5};
        vecs[7]  = '{5'h10, 32'h00000000, 4'hF, 2'b00, 5'h10, 32'h454D0001, 2'b00, 4'h5};
        vecs[8]  = '{5'h14, 32'h00000001, 4'hF, 2'b10, 5'h18, 32'h00000000, 2'b10, 4'h5};
        vecs[9]  = '{5'h1C, 32'h00000001, 4'hF, 2'b10, 5'h1C, 32'h00000000, 2'b10, 4'h5};
        vecs[10] = '{5'h03, 32'h00000003, 4'hF, 2'b00, 5'h01, 32'h00000003, 2'b00, 4'h3};
        vecs[11] = '{5'h08, 32'h0000000F, 4'hF, 2'b00, 5'h08, 32'h00000000, 2'b00, 4'h3};

        // Reset
        tick(3);
        check("reset_bvalid", {31'd0, bvalid}, 32'd0);
        check("reset_rvalid", {31'd0, rvalid}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_resp", {28'd0, bresp, rresp}, 32'd0);
        check("reset_leds", {28'd0, leds}, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        tick(2);
        check("idle_ready", {29'd0, awready, wready, arready}, 32'd0);

        // Write with aw/w together, B stalled, a second write queued behind it
        awaddr = 5'h00; wdata = 32'h0000000A; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        #1;
        check("t1_ready_both", {30'd0, awready, wready}, 32'd3);
        check("t1_leds_before", {28'd0, leds}, 32'd0);
        tick(1);
        wdata = 32'h00000005;
        #1;
        check("t1_leds_after", {28'd0, leds}, 32'hA);
        for (int i = 0; i < 5; i++) begin
            check("t1_bvalid_stall", {31'd0, bvalid}, 32'd1);
            check("t1_bresp_stall", {30'd0, bresp}, 32'd0);
            check("t1_no_accept_in_resp", {30'd0, awready, wready}, 32'd0);
            tick(1);
        end
        bready = 1'b1;
        tick(1);
        check("t1_bvalid_drop", {31'd0, bvalid}, 32'd0);
        check("t1_next_accept", {30'd0, awready, wready}, 32'd3);
        tick(1);
        awvalid = 1'b0; wvalid = 1'b0;
        check("t1_second_write", {28'd0, leds}, 32'h5);
        check("t1_second_bvalid", {31'd0, bvalid}, 32'd1);
        tick(1);
        bready = 1'b0;

        // AW leads W by three cycles
        awaddr = 5'h0C; awvalid = 1'b1; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_no_ready_aw_only", {30'd0, awready, wready}, 32'd0);
            tick(1);
        end
        wdata = 32'h00000002; wstrb = 4'hF; wvalid = 1'b1;
        #1;
        check("t2_ready_both", {30'd0, awready, wready}, 32'd3);
        tick(1);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        check("t2_bvalid", {31'd0, bvalid}, 32'd1);
        tick(1);
        bready = 1'b0;
        axi_read(5'h0C, d, r);
        check("t2_irq_en_read", d, 32'h2);
        axi_read(5'h10, d, r);
        check("t2_id_read", d, 32'h454D0001);
        check("t2_id_rresp", {30'd0, r}, 32'd0);

        // Register table
        for (int i = 0; i < 12; i++) begin
            axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, r);
            check($sformatf("vec%0d_bresp", i), {30'd0, r}, {30'd0, vecs[i].exp_bresp});
            check($sformatf("vec%0d_leds", i), {28'd0, leds}, {28'd0, vecs[i].exp_leds});
            axi_read(vecs[i].raddr, d, r);
            check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
            check($sformatf("vec%0d_rresp", i), {30'd0, r}, {30'd0, vecs[i].exp_rresp});
        end

        // Glitch shorter than the debounce window is rejected
        sws[0] = 1'b1;
        tick(5);
        sws[0] = 1'b0;
        tick(15);
        axi_read(5'h04, d, r);
        check("t3_glitch_sw_in", d, 32'h0);
        axi_read(5'h08, d, r);
        check("t3_glitch_edge", d, 32'h0);

        // Debounce latency observed through the interrupt
        axi_write(5'h0C, 32'h4, 4'hF, r);
        sws[2] = 1'b1;
        tick(10);
        check("t3_irq_not_yet", {31'd0, irq}, 32'd0);
        tick(1);
        check("t4_irq_rise", {31'd0, irq}, 32'd1);
        axi_read(5'h04, d, r);
        check("t3_sw_in", d, 32'h4);
        axi_read(5'h08, d, r);
        check("t4_sw_edge", d, 32'h4);
        axi_write(5'h08, 32'h4, 4'hF, r);
        check("t4_irq_cleared", {31'd0, irq}, 32'd0);
        axi_read(5'h08, d, r);
        check("t4_edge_cleared", d, 32'h0);

        // Falling debounce re-arms the flag, then clear collides with the next rise
        sws[2] = 1'b0;
        tick(10);
        check("t5_fall_irq_not_yet", {31'd0, irq}, 32'd0);
        tick(1);
        check("t5_fall_irq", {31'd0, irq}, 32'd1);
        axi_read(5'h04, d, r);
        check("t5_fall_sw_in", d, 32'h0);
        sws[2] = 1'b1;
        tick(9);
        axi_write(5'h08, 32'h4, 4'hF, r);
        check("t5_irq_held", {31'd0, irq}, 32'd1);
        axi_read(5'h08, d, r);
        check("t5_edge_held", d, 32'h4);
        check("t5_irq_still_held", {31'd0, irq}, 32'd1);
        axi_read(5'h04, d, r);
        check("t5_sw_in", d, 32'h4);
        axi_write(5'h08, 32'h4, 4'hF, r);
        check("t5_irq_cleared", {31'd0, irq}, 32'd0);

        // Reset while a read response is pending
        araddr = 5'h10; arvalid = 1'b1; rready = 1'b0;
        tick(1);
        arvalid = 1'b0;
        check("t6_rvalid_pending", {31'd0, rvalid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rvalid_async_drop", {31'd0, rvalid}, 32'd0);
        check("t6_rdata_reset", rdata, 32'd0);
        check("t6_leds_reset", {28'd0, leds}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("t6_rvalid_after", {31'd0, rvalid}, 32'd0);
        tick(14);
        axi_read(5'h04, d, r);
        check("t6_held_switch_sw_in", d, 32'h4);
        axi_read(5'h08, d, r);
        check("t6_held_switch_edge", d, 32'h4);
        axi_read(5'h00, d, r);
        check("t6_led_after_reset", d, 32'h0);
        check("t6_rresp_after_reset", {30'd0, r}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
